sevenseg_scan_decoder: RTL and testbench
========================================

// Module: sevenseg_scan_decoder
// PURPOSE
//   Reverse path of the clock/stopwatch display encoder. Samples a time-multiplexed,
//   active-low 7-segment bus (one shared segment bus, one-hot digit select) and decodes
//   each pattern back to a digit. Assembles the six clock digits into binary
//   second/minute/hour and publishes them only after STABLE_FRAMES identical valid frames.
//   Used as a display-readback monitor in board self-test and in the display bench.
// PARAMETERS
//   SYNC_STAGES     2     synchroniser depth on seg_in, digit_sel and sample_en (>=2)
//   STABLE_FRAMES   2     consecutive identical valid frames required before commit (>=1)
//   TIMEOUT_CYCLES  1024  max cycles from the first accepted digit to frame completion
// PORTS
//   clk            in   1  system clock, all logic on rising edge
//   reset_n        in   1  asynchronous, active-low reset
//   seg_in         in   7  segment bus {g,f,e,d,c,b,a}, active-low (0 -> 7'b1000000)
//   digit_sel      in   6  one-hot digit select: [0] sec ones, [1] sec tens, [2] min ones,
//                          [3] min tens, [4] hour ones, [5] hour tens
//   sample_en      in   1  seg_in/digit_sel are valid in this cycle
//   second         out  6  committed seconds, 0..59
//   minute         out  6  committed minutes, 0..59
//   hour           out  5  committed hours, 0..23
//   time_valid     out  1  1-cycle pulse when a committed value differs from the previous one
//   locked         out  1  high after the first commit; low after any error or timeout
//   decode_err     out  1  1-cycle pulse: sampled pattern is not one of the ten digit codes
//   sel_err        out  1  1-cycle pulse: digit_sel not one-hot while sample_en is high
//   range_err      out  1  1-cycle pulse: complete frame out of range
//   frame_timeout  out  1  1-cycle pulse: frame not completed within TIMEOUT_CYCLES
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, shadow/seen/last_frame cleared,
//   match_cnt=0, timeout counter=0, FSM=COLLECT. Asserting reset mid-frame discards everything.
// - All three inputs pass through the same SYNC_STAGES flops, so they stay mutually aligned.
//   "Accepted" below refers to the synchronised signals.
// - Decode codes: 1000000=0 1111001=1 0100100=2 0110000=3 0011001=4 0010010=5 0000010=6
//   1111000=7 0000000=8 0010000=9. Any other code, including blank 1111111, is invalid.
// - FSM COLLECT:
//   - On sample_en with one-hot digit_sel and a valid code: write the digit into
//     shadow[idx] and set seen[idx]. A repeated digit overwrites the shadow; seen stays set.
//   - Invalid code: decode_err, clear seen, clear match_cnt, clear locked.
//   - Non-one-hot digit_sel (including all-zero): sel_err, sample ignored, seen unchanged.
//   - Timeout counter: starts on the first accepted digit of a frame (seen==0). When it
//     reaches TIMEOUT_CYCLES before seen==6'h3F: frame_timeout, clear seen, clear
//     match_cnt, clear locked.
//   - When seen becomes 6'h3F on cycle T: go to EVAL at T+1. Samples arriving during
//     EVAL/COMMIT are dropped silently.
// - FSM EVAL (1 cycle):
//   - Compute s=10*tens+ones for each field, using 7-bit intermediates.
//   - Range check s<=59, m<=59, h<=23. On failure: range_err, clear match_cnt and locked,
//     go to COLLECT.
//   - If the frame equals last_frame: match_cnt++ (saturate at STABLE_FRAMES).
//     Otherwise: last_frame=frame, match_cnt=1.
//   - If match_cnt is now >= STABLE_FRAMES, go to COMMIT; else go to COLLECT.
//   - seen is cleared on leaving EVAL.
// - FSM COMMIT (1 cycle, T+2):
//   - Load second/minute/hour and set locked.
//   - time_valid=1 iff the new triple differs from the registered outputs, or this is
//     the first commit since reset or since locked fell. Then go to COLLECT.
// - Error pulses are mutually exclusive per cycle. Precedence: sel_err > decode_err.
//   frame_timeout wins over a sample in the same cycle; that sample is discarded.
// - Pulse outputs are registered, 1 cycle wide, and never asserted during reset.
// TESTING
// 1. Scan 12:34:56 twice (STABLE_FRAMES=2) -> second=56 minute=34 hour=12 at T+2 of
//    frame 2; time_valid 1 cycle; locked=1.
// 2. Scan 12:34:56 a third time -> outputs held, no time_valid. Then 12:34:57 twice ->
//    second=57 with one time_valid.
// 3. Inject seg_in=7'b1111111 on digit 2 mid-frame -> decode_err; locked=0; frame and
//    match_cnt discarded; the next two good frames recommit with time_valid.
// 4. digit_sel=6'b000011 with sample_en -> sel_err, seen unchanged, frame still completes.
// 5. Frame 25:00:00 -> range_err, no output change. Five digits then silence ->
//    frame_timeout exactly TIMEOUT_CYCLES after the first digit.
// 6. Assert reset_n=0 between frame 1 and frame 2 of case 1 -> all outputs 0 immediately;
//    two further frames are needed to commit.

Source files
------------

// File: rtl/sevenseg_scan_decoder.sv
// Display readback monitor: samples a multiplexed active-low 7-segment bus,
// decodes each digit, assembles hh:mm:ss and commits the time only after
// STABLE_FRAMES identical, in-range frames have been scanned back to back.
`timescale 1ns/1ps
module sevenseg_scan_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
)(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] seg_in,
  input  logic [5:0] digit_sel,
  input  logic       sample_en,
  output logic [5:0] second,
  output logic [5:0] minute,
  output logic [4:0] hour,
  output logic       time_valid,
  output logic       locked,
  output logic       decode_err,
  output logic       sel_err,
  output logic       range_err,
  output logic       frame_timeout
);

  localparam int MW = (STABLE_FRAMES  < 1) ? 1 : $clog2(STABLE_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {COLLECT, EVAL, COMMIT} state_t;

  // Segment pattern -> {valid, digit}; anything off-table (blank included) is invalid.
  function automatic logic [4:0] seg_decode(input logic [6:0] c);
    case (c)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0010000: return {1'b1, 4'd9};
      default:    return 5'b0_0000;
    endcase
  endfunction

  // 10*tens + ones; 7 bits covers the worst case 99 so range checks see the true value.
  function automatic logic [6:0] to_bin(input logic [3:0] t, input logic [3:0] o);
    return 7'd10 * {3'b000, t} + {3'b000, o};
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchroniser: bus, select and strobe share one chain so they stay aligned
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][13:0] r_sync;

  // Shift {sample_en, digit_sel, seg_in} through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= {sample_en, digit_sel, seg_in};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  logic [6:0] w_seg;
  logic [5:0] w_sel;
  logic       w_en;
  logic [4:0] w_dig;
  logic       w_dig_ok;
  logic       w_onehot;

  assign w_seg    = r_sync[SYNC_STAGES-1][6:0];
  assign w_sel    = r_sync[SYNC_STAGES-1][12:7];
  assign w_en     = r_sync[SYNC_STAGES-1][13];
  assign w_dig    = seg_decode(w_seg);
  assign w_dig_ok = w_dig[4];
  assign w_onehot = (w_sel != 6'd0) && ((w_sel & (w_sel - 6'd1)) == 6'd0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              r_state, w_state_nx;
  logic [5:0][3:0]     r_shadow;     // digits of the frame being collected
  logic [5:0][3:0]     r_last;       // last in-range frame seen, for stability matching
  logic [5:0]          r_seen;
  logic [TW-1:0]       r_tcnt;
  logic [MW-1:0]       r_match;
  logic                r_locked;
  logic [5:0]          r_second, r_minute;
  logic [4:0]          r_hour;
  logic                r_time_valid, r_decode_err, r_sel_err, r_range_err, r_frame_timeout;

  // Field values of the collected frame (range check) and of the frame to commit.
  logic [6:0] w_f_sec, w_f_min, w_f_hr;
  logic [6:0] w_c_sec, w_c_min, w_c_hr;
  logic       w_range_ok;

  assign w_f_sec    = to_bin(r_shadow[1], r_shadow[0]);
  assign w_f_min    = to_bin(r_shadow[3], r_shadow[2]);
  assign w_f_hr     = to_bin(r_shadow[5], r_shadow[4]);
  assign w_range_ok = (w_f_sec <= 7'd59) && (w_f_min <= 7'd59) && (w_f_hr <= 7'd23);
  assign w_c_sec    = to_bin(r_last[1], r_last[0]);
  assign w_c_min    = to_bin(r_last[3], r_last[2]);
  assign w_c_hr     = to_bin(r_last[5], r_last[4]);

  // Next-state and strobe signals produced by the FSM for the datapath.
  logic [5:0]    w_seen_nx;
  logic [TW-1:0] w_tcnt_nx;
  logic [MW-1:0] w_match_nx;
  logic          w_wr, w_last_ld, w_out_ld, w_locked_nx;
  logic          w_tv_nx, w_dec_nx, w_sel_nx, w_rng_nx, w_tmo_nx;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= COLLECT;
    else          r_state <= w_state_nx;
  end

  // FSM next state and datapath controls; timeout beats any sample in the same cycle.
  always_comb begin
    w_state_nx  = r_state;
    w_seen_nx   = r_seen;
    w_tcnt_nx   = r_tcnt;
    w_match_nx  = r_match;
    w_locked_nx = r_locked;
    w_wr        = 1'b0;
    w_last_ld   = 1'b0;
    w_out_ld    = 1'b0;
    w_tv_nx     = 1'b0;
    w_dec_nx    = 1'b0;
    w_sel_nx    = 1'b0;
    w_rng_nx    = 1'b0;
    w_tmo_nx    = 1'b0;
    case (r_state)
      COLLECT: begin
        if (r_seen != 6'd0) w_tcnt_nx = r_tcnt + TW'(1);
        if ((r_seen != 6'd0) && (r_tcnt == TMO_MAX)) begin
          w_tmo_nx    = 1'b1;
          w_seen_nx   = 6'd0;
          w_tcnt_nx   = '0;
          w_match_nx  = '0;
          w_locked_nx = 1'b0;
        end else if (w_en) begin
          if (!w_onehot) begin
            w_sel_nx = 1'b1;
          end else if (!w_dig_ok) begin
            w_dec_nx    = 1'b1;
            w_seen_nx   = 6'd0;
            w_tcnt_nx   = '0;
            w_match_nx  = '0;
            w_locked_nx = 1'b0;
          end else begin
            w_wr      = 1'b1;
            w_seen_nx = r_seen | w_sel;
            if (r_seen == 6'd0) w_tcnt_nx = TW'(1);
            if (w_seen_nx == 6'h3F) w_state_nx = EVAL;
          end
        end
      end
      EVAL: begin
        w_seen_nx  = 6'd0;
        w_tcnt_nx  = '0;
        w_state_nx = COLLECT;
        if (!w_range_ok) begin
          w_rng_nx    = 1'b1;
          w_match_nx  = '0;
          w_locked_nx = 1'b0;
        end else begin
          if (r_shadow == r_last) begin
            w_match_nx = (r_match >= MATCH_MAX) ? MATCH_MAX : r_match + MW'(1);
          end else begin
            w_last_ld  = 1'b1;
            w_match_nx = MW'(1);
          end
          if (w_match_nx >= MATCH_MAX) w_state_nx = COMMIT;
        end
      end
      COMMIT: begin
        w_out_ld    = 1'b1;
        w_locked_nx = 1'b1;
        // Announce only real changes, except the first commit after lock was lost.
        w_tv_nx     = (w_c_sec != {1'b0, r_second}) || (w_c_min != {1'b0, r_minute}) ||
                      (w_c_hr != {2'b00, r_hour}) || !r_locked;
        w_state_nx  = COLLECT;
      end
      default: w_state_nx = COLLECT;
    endcase
  end

  // Datapath registers: shadow digits, frame tracking, committed time and pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow        <= '0;
      r_last          <= '0;
      r_seen          <= '0;
      r_tcnt          <= '0;
      r_match         <= '0;
      r_locked        <= 1'b0;
      r_second        <= '0;
      r_minute        <= '0;
      r_hour          <= '0;
      r_time_valid    <= 1'b0;
      r_decode_err    <= 1'b0;
      r_sel_err       <= 1'b0;
      r_range_err     <= 1'b0;
      r_frame_timeout <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++)
        if (w_wr && w_sel[i]) r_shadow[i] <= w_dig[3:0];
      if (w_last_ld) r_last <= r_shadow;
      if (w_out_ld) begin
        r_second <= w_c_sec[5:0];
        r_minute <= w_c_min[5:0];
        r_hour   <= w_c_hr[4:0];
      end
      r_seen          <= w_seen_nx;
      r_tcnt          <= w_tcnt_nx;
      r_match         <= w_match_nx;
      r_locked        <= w_locked_nx;
      r_time_valid    <= w_tv_nx;
      r_decode_err    <= w_dec_nx;
      r_sel_err       <= w_sel_nx;
      r_range_err     <= w_rng_nx;
      r_frame_timeout <= w_tmo_nx;
    end
  end

  assign second        = r_second;
  assign minute        = r_minute;
  assign hour          = r_hour;
  assign time_valid    = r_time_valid;
  assign locked        = r_locked;
  assign decode_err    = r_decode_err;
  assign sel_err       = r_sel_err;
  assign range_err     = r_range_err;
  assign frame_timeout = r_frame_timeout;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder: scans clock frames onto the
// multiplexed bus and checks commits, error pulses, timeout and reset.
`timescale 1ns/1ps
module tb_sevenseg_scan_decoder;

  localparam int SYNC = 2;
  localparam int STAB = 2;
  localparam int TMO  = 1024;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] seg_in;
  logic [5:0] digit_sel;
  logic       sample_en;
  logic [5:0] second, minute;
  logic [4:0] hour;
  logic       time_valid, locked, decode_err, sel_err, range_err, frame_timeout;

  sevenseg_scan_decoder #(.SYNC_STAGES(SYNC), .STABLE_FRAMES(STAB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .digit_sel(digit_sel),
    .sample_en(sample_en), .second(second), .minute(minute), .hour(hour),
    .time_valid(time_valid), .locked(locked), .decode_err(decode_err),
    .sel_err(sel_err), .range_err(range_err), .frame_timeout(frame_timeout));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, drv_cyc = 0;
  int cnt_tv = 0, cnt_tv_wide = 0, cnt_dec = 0, cnt_sel = 0, cnt_rng = 0, cnt_tmo = 0;
  int b_tv, b_dec, b_sel, b_rng, b_tmo;
  logic tv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (time_valid) cnt_tv <= cnt_tv + 1;
    if (time_valid && tv_prev) cnt_tv_wide <= cnt_tv_wide + 1;
    tv_prev <= time_valid;
    if (decode_err)    cnt_dec <= cnt_dec + 1;
    if (sel_err)       cnt_sel <= cnt_sel + 1;
    if (range_err)     cnt_rng <= cnt_rng + 1;
    if (frame_timeout) cnt_tmo <= cnt_tmo + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
      3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
      6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
      9: return 7'b0010000; default: return 7'b1111111;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_tv = cnt_tv; b_dec = cnt_dec; b_sel = cnt_sel; b_rng = cnt_rng; b_tmo = cnt_tmo;
  endtask

  task automatic send_raw(input logic [5:0] sel, input logic [6:0] seg);
    @(negedge clk);
    drv_cyc = cyc; seg_in = seg; digit_sel = sel; sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0; digit_sel = 6'd0; seg_in = 7'h7F;
  endtask

  task automatic send_digit(input int idx, input int d);
    send_raw(6'(1 << idx), enc(d));
  endtask

  task automatic send_frame(input int h, input int m, input int s);
    send_digit(0, s % 10); send_digit(1, s / 10);
    send_digit(2, m % 10); send_digit(3, m / 10);
    send_digit(4, h % 10); send_digit(5, h / 10);
  endtask

  // Waits for time_valid after a frame; checks latency, values and pulse width.
  task automatic expect_commit(input string tag, input int h, input int m, input int s);
    int k;
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (time_valid) begin k = i; break; end
    end
    chk({tag, "_lat"}, k, SYNC + 2);
    chk({tag, "_sec"}, int'(second), s);
    chk({tag, "_min"}, int'(minute), m);
    chk({tag, "_hr"},  int'(hour), h);
    chk({tag, "_lock"}, int'(locked), 1);
    @(negedge clk);
    chk({tag, "_tv_width"}, int'(time_valid), 0);
  endtask

  initial begin
    int tt;
    reset_n = 1'b0; seg_in = 7'h7F; digit_sel = 6'd0; sample_en = 1'b0;
    idle(3);
    chk("rst_sec", int'(second), 0);
    chk("rst_min", int'(minute), 0);
    chk("rst_hr", int'(hour), 0);
    chk("rst_lock", int'(locked), 0);
    chk("rst_pulses", int'({time_valid, decode_err, sel_err, range_err, frame_timeout}), 0);
    @(negedge clk); reset_n = 1'b1;
    idle(2);

    // 12:34:56 twice commits on the second frame
    snap();
    send_frame(12, 34, 56); idle(8);
    chk("c1_f1_tv", cnt_tv - b_tv, 0);
    chk("c1_f1_lock", int'(locked), 0);
    chk("c1_f1_sec", int'(second), 0);
    send_frame(12, 34, 56);
    expect_commit("c1_f2", 12, 34, 56);
    idle(4);
    chk("c1_tv_cnt", cnt_tv - b_tv, 1);

    // same time again: held, silent; then 12:34:57 twice
    snap();
    send_frame(12, 34, 56); idle(8);
    chk("c2_same_tv", cnt_tv - b_tv, 0);
    chk("c2_same_sec", int'(second), 56);
    chk("c2_same_lock", int'(locked), 1);
    send_frame(12, 34, 57); idle(8);
    chk("c2_new1_tv", cnt_tv - b_tv, 0);
    chk("c2_new1_sec", int'(second), 56);
    send_frame(12, 34, 57);
    expect_commit("c2_new2", 12, 34, 57);
    idle(4);
    chk("c2_tv_cnt", cnt_tv - b_tv, 1);

    // blank pattern on digit 2 mid-frame
    snap();
    send_digit(0, 7); send_digit(1, 5); send_raw(6'b000100, 7'h7F);
    idle(6);
    chk("c3_dec", cnt_dec - b_dec, 1);
    chk("c3_lock", int'(locked), 0);
    chk("c3_sec_held", int'(second), 57);
    send_frame(12, 34, 57); idle(8);
    chk("c3_f1_tv", cnt_tv - b_tv, 0);
    send_frame(12, 34, 57);
    expect_commit("c3_f2", 12, 34, 57);
    idle(4);
    chk("c3_tv_cnt", cnt_tv - b_tv, 1);
    chk("c3_dec_total", cnt_dec - b_dec, 1);

    // two-hot select mid-frame is ignored and the frame still completes
    snap();
    send_digit(0, 8); send_digit(1, 5); send_digit(2, 4);
    send_raw(6'b000011, enc(8));
    send_digit(3, 3); send_digit(4, 2); send_digit(5, 1);
    idle(8);
    chk("c4_sel", cnt_sel - b_sel, 1);
    chk("c4_dec", cnt_dec - b_dec, 0);
    chk("c4_rng", cnt_rng - b_rng, 0);
    chk("c4_f1_tv", cnt_tv - b_tv, 0);
    send_frame(12, 34, 58);
    expect_commit("c4_f2", 12, 34, 58);
    idle(4);
    chk("c4_tv_cnt", cnt_tv - b_tv, 1);

    // hour 25 is out of range
    snap();
    send_frame(25, 0, 0); idle(8);
    chk("c5_rng", cnt_rng - b_rng, 1);
    chk("c5_tv", cnt_tv - b_tv, 0);
    chk("c5_sec", int'(second), 58);
    chk("c5_hr", int'(hour), 12);
    chk("c5_lock", int'(locked), 0);

    // five digits then silence: timeout TMO cycles after the first digit is accepted
    snap();
    send_digit(0, 0);
    tt = drv_cyc;
    send_digit(1, 0); send_digit(2, 0); send_digit(3, 0); send_digit(4, 0);
    begin
      int hit;
      hit = -1;
      for (int i = 0; i < TMO + 200; i++) begin
        @(negedge clk);
        if (frame_timeout) begin hit = cyc - tt; break; end
      end
      chk("c5_tmo_lat", hit, TMO + SYNC + 1);
    end
    idle(2);
    chk("c5_tmo_cnt", cnt_tmo - b_tmo, 1);
    chk("c5_tmo_dec", cnt_dec - b_dec, 0);
    chk("c5_tmo_lock", int'(locked), 0);

    // reset between two frames discards the first one
    send_frame(1, 2, 3); idle(4);
    @(negedge clk); reset_n = 1'b0; #1;
    chk("c6_rst_sec", int'(second), 0);
    chk("c6_rst_min", int'(minute), 0);
    chk("c6_rst_hr", int'(hour), 0);
    chk("c6_rst_lock", int'(locked), 0);
    idle(2);
    @(negedge clk); reset_n = 1'b1;
    idle(2);
    snap();
    send_frame(1, 2, 3); idle(8);
    chk("c6_f1_tv", cnt_tv - b_tv, 0);
    chk("c6_f1_sec", int'(second), 0);
    send_frame(1, 2, 3);
    expect_commit("c6_f2", 1, 2, 3);

    // upper range boundary accepted, minute 60 rejected
    send_frame(23, 59, 59); idle(8);
    send_frame(23, 59, 59);
    expect_commit("max", 23, 59, 59);
    snap();
    send_frame(0, 60, 0); idle(8);
    chk("m60_rng", cnt_rng - b_rng, 1);
    chk("m60_sec", int'(second), 59);
    chk("m60_lock", int'(locked), 0);
    chk("tv_width_total", cnt_tv_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
